// File: rtl/dpm_pkg.sv
// Shared constants, state/port types and the fill pattern for the dpm_bist_ctrl self-test.
// Optional second inverted pass is enabled by DPM_BIST_INVERT_EN (see dpm_bist_ctrl).
package dpm_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int ERR_W  = 11;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    RD_A,
    RD_B,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  // Every location holds the low bits of its own address.
  function automatic logic [DATA_W-1:0] exp_pat(input logic [ADDR_W-1:0] a);
    return a[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dpm_bist_ctrl_if.sv
// Both request ports of double_port_mem as seen from the requester (master) and the memory (slave).
interface dpm_bist_ctrl_if;
  import dpm_pkg::*;

  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] in_a;
  logic              w_a;
  logic              en_a;
  logic [DATA_W-1:0] out_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] in_b;
  logic              w_b;
  logic              en_b;
  logic [DATA_W-1:0] out_b;

  modport master (
    output addr_a, in_a, w_a, en_a, addr_b, in_b, w_b, en_b,
    input  out_a, out_b
  );

  modport slave (
    input  addr_a, in_a, w_a, en_a, addr_b, in_b, w_b, en_b,
    output out_a, out_b
  );

endinterface

// File: rtl/dpm_rd_checker.sv
// Readback checker: one-stage read pipe, data compare, saturating error count, first-error capture.
module dpm_rd_checker
  import dpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_rd_vld,
  input  port_t             i_rd_port,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_rd_exp,
  input  logic [DATA_W-1:0] i_out_a,
  input  logic [DATA_W-1:0] i_out_b,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic              o_err_seen_next
);

  logic              r_vld;
  port_t             r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_exp;
  logic [ERR_W-1:0]  r_err_count;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              r_err_seen;
  logic [DATA_W-1:0] w_data;
  logic              w_mismatch;

  assign w_data          = (r_port == PORT_A) ? i_out_a : i_out_b;
  assign w_mismatch      = r_vld && (w_data != r_exp);
  // Includes the compare resolving this cycle, so the final verdict can be latched on the same edge.
  assign o_err_seen_next = r_err_seen | w_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld            <= 1'b0;
      r_port           <= PORT_A;
      r_addr           <= '0;
      r_exp            <= '0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_err_seen       <= 1'b0;
    end else begin
      r_vld <= i_rd_vld;
      if (i_rd_vld) begin
        r_port <= i_rd_port;
        r_addr <= i_rd_addr;
        r_exp  <= i_rd_exp;
      end
      if (i_clr) begin
        r_err_count      <= '0;
        r_first_err_addr <= '0;
        r_err_seen       <= 1'b0;
      end else if (w_mismatch) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
        if (!r_err_seen) begin
          r_err_seen       <= 1'b1;
          r_first_err_addr <= r_addr;
        end
      end
    end
  end

  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/dpm_bist_ctrl.sv
// Fill/readback self-test sequencer for double_port_mem; FSM and address counters live here.
// Define DPM_BIST_INVERT_EN to add a second pass using the inverted pattern.
module dpm_bist_ctrl
  import dpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  dpm_bist_ctrl_if.master   mem
);

  localparam logic [ADDR_W-1:0] ZERO    = '0;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] HALF    = ADDR_W'(DEPTH / 2);
  localparam logic [ADDR_W-1:0] HALF_M1 = ADDR_W'(DEPTH / 2 - 1);

  state_t            r_state;
  logic              r_busy, r_done, r_pass;
  logic              r_w_a, r_en_a, r_w_b, r_en_b;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b;
  logic [DATA_W-1:0] r_in_a, r_in_b;
  logic [DATA_W-1:0] w_flip;
  logic              w_accept;
  logic              w_err_seen_next;
  port_t             w_rd_port;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_exp;

`ifdef DPM_BIST_INVERT_EN
  logic r_inv;
  assign w_flip = {DATA_W{r_inv}};
`else
  assign w_flip = '0;
`endif

  assign w_accept  = (r_state == IDLE) && start;
  assign w_rd_port = r_en_b ? PORT_B : PORT_A;
  assign w_rd_addr = r_en_b ? r_addr_b : r_addr_a;
  assign w_rd_exp  = exp_pat(w_rd_addr) ^ w_flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_w_a    <= 1'b0;
      r_en_a   <= 1'b0;
      r_w_b    <= 1'b0;
      r_en_b   <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_in_a   <= '0;
      r_in_b   <= '0;
`ifdef DPM_BIST_INVERT_EN
      r_inv    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= WR_A;
            r_busy   <= 1'b1;
            r_pass   <= 1'b0;
            r_w_a    <= 1'b1;
            r_addr_a <= ZERO;
            r_in_a   <= exp_pat(ZERO);
`ifdef DPM_BIST_INVERT_EN
            r_inv    <= 1'b0;
`endif
          end
        end
        WR_A: begin
          if (r_addr_a == HALF_M1) begin
            r_state  <= WR_B;
            r_w_a    <= 1'b0;
            r_w_b    <= 1'b1;
            r_addr_b <= HALF;
            r_in_b   <= exp_pat(HALF) ^ w_flip;
          end else begin
            r_addr_a <= r_addr_a + ADDR_W'(1);
            r_in_a   <= exp_pat(r_addr_a + ADDR_W'(1)) ^ w_flip;
          end
        end
        WR_B: begin
          if (r_addr_b == LAST) begin
            r_state  <= RD_A;
            r_w_b    <= 1'b0;
            r_en_a   <= 1'b1;
            r_addr_a <= LAST;
          end else begin
            r_addr_b <= r_addr_b + ADDR_W'(1);
            r_in_b   <= exp_pat(r_addr_b + ADDR_W'(1)) ^ w_flip;
          end
        end
        // Each half is read back through the port that did not write it, top address first.
        RD_A: begin
          if (r_addr_a == HALF) begin
            r_state  <= RD_B;
            r_en_a   <= 1'b0;
            r_en_b   <= 1'b1;
            r_addr_b <= HALF_M1;
          end else begin
            r_addr_a <= r_addr_a - ADDR_W'(1);
          end
        end
        RD_B: begin
          if (r_addr_b == ZERO) begin
            r_state <= DRAIN;
            r_en_b  <= 1'b0;
          end else begin
            r_addr_b <= r_addr_b - ADDR_W'(1);
          end
        end
        DRAIN: begin
`ifdef DPM_BIST_INVERT_EN
          if (!r_inv) begin
            r_inv    <= 1'b1;
            r_state  <= WR_A;
            r_w_a    <= 1'b1;
            r_addr_a <= ZERO;
            r_in_a   <= ~exp_pat(ZERO);
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_err_seen_next;
          end
`else
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= !w_err_seen_next;
`endif
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dpm_rd_checker u_rd_checker (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_clr            (w_accept),
    .i_rd_vld         (r_en_a | r_en_b),
    .i_rd_port        (w_rd_port),
    .i_rd_addr        (w_rd_addr),
    .i_rd_exp         (w_rd_exp),
    .i_out_a          (mem.out_a),
    .i_out_b          (mem.out_b),
    .o_err_count      (err_count),
    .o_first_err_addr (first_err_addr),
    .o_err_seen_next  (w_err_seen_next)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign mem.addr_a = r_addr_a;
  assign mem.in_a   = r_in_a;
  assign mem.w_a    = r_w_a;
  assign mem.en_a   = r_en_a;
  assign mem.addr_b = r_addr_b;
  assign mem.in_b   = r_in_b;
  assign mem.w_b    = r_w_b;
  assign mem.en_b   = r_en_b;

endmodule

// File: doc/dpm_bist_ctrl.md
Name: dpm_bist_ctrl

Overview:
- Self-test initiator for the 1024x8 dual-ported memory `double_port_mem`. Drives both memory ports from the requester side.
- Fills the lower half through port A and the upper half through port B. Reads each half back through the opposite port, in descending order, and compares against the expected pattern.
- Sits beside the memory and replaces bench-driven fill/readback in system test. Reports pass/fail, error count and first failing address.

Parameters:
- ADDR_W, 10, memory address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, memory data width.
- ERR_W, 11, error counter width; the counter saturates at all-ones.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid while done is high and held until the next start; 1 means zero mismatches.
- err_count  out  ERR_W  number of read mismatches, saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if there was none.
- addr_a, in_a, w_a, en_a  out  ADDR_W, DATA_W, 1, 1  port A request.
- out_a  in  DATA_W  port A read data.
- addr_b, in_b, w_b, en_b  out  ADDR_W, DATA_W, 1, 1  port B request.
- out_b  in  DATA_W  port B read data.

Behaviour:
- Memory contract:
  - Write: w=1 at a rising edge writes in to addr. en is not required for a write.
  - Read: en=1 and w=0 issues a read. out is valid exactly one cycle later.
  - The block never drives w=1 and en=1 together on the same port.
- Reset values: all outputs 0, state IDLE, error counter 0, first_err_addr 0, error-seen flag 0.
- States and transitions:
  - IDLE: on start go to WR_A; clear err_count, first_err_addr and pass.
  - WR_A: w_a=1, addr_a steps 0..DEPTH/2-1, one per cycle; in_a = addr[DATA_W-1:0]. Go to WR_B after the last address.
  - WR_B: w_b=1, addr_b steps DEPTH/2..DEPTH-1; in_b = addr[DATA_W-1:0]. Go to RD_A.
  - RD_A: en_a=1, addr_a steps DEPTH-1 down to DEPTH/2. Go to RD_B.
  - RD_B: en_b=1, addr_b steps DEPTH/2-1 down to 0. Go to DRAIN.
  - DRAIN: one cycle, no requests; the last compare completes. Go to DONE.
  - DONE: done=1 and busy=0 for one cycle; pass = (err_count==0). Go to IDLE.
- Idle drive: outside their active phase, w_x and en_x are 0. addr_x and in_x hold their last value.
- Readback compare:
  - Each issued read pushes {port, addr} into a one-stage valid pipe.
  - On the next cycle, the data from the selected port is compared with addr[DATA_W-1:0].
  - The last RD_A compare overlaps the first RD_B issue. Both must be handled correctly.
- On a mismatch: err_count increments and saturates. If this is the first error, first_err_addr captures the address.
- Timing: a single run takes 4*(DEPTH/2) + 2 cycles from the start-accept edge to the done pulse (2050 at defaults).
- start while busy is ignored.
- Reset asserted mid-run: immediate return to the reset values. No done pulse is generated.

Optional Feature:
- Macro DPM_BIST_INVERT_EN.
- Defined:
  - After the RD_B pass, the block re-enters WR_A with an internal inv flag set.
  - The second pass writes and expects ~addr[DATA_W-1:0].
  - Errors accumulate across both passes. done pulses only after the second DRAIN.
  - Run length becomes 2*(4*(DEPTH/2)+1)+1 cycles (4099 at defaults).
- Undefined: single pass only; inv logic is absent.

Decomposition:
- Package dpm_pkg:
  - ADDR_W, DATA_W and DEPTH constants.
  - State enum: IDLE, WR_A, WR_B, RD_A, RD_B, DRAIN, DONE.
  - Port-select typedef PORT_A/PORT_B.
- Sub-module dpm_rd_checker:
  - Contains the one-stage read-valid pipe, the data comparator, the saturating err_count and the first_err_addr capture.
  - The top holds the FSM and address counters.

Test Plan:
- Ideal memory model, start pulsed once → busy high for 2049 cycles, done pulse at cycle 2050, pass=1, err_count=0, first_err_addr=0.
- Model with bit0 of address 700 stuck-at-1 → err_count=1, first_err_addr=700, pass=0. Address 700 is checked via port A read.
- Model with addresses 5 and 3 corrupted → err_count=2, first_err_addr=5, because the read order is descending.
- start held high for 3 cycles, then start pulsed again mid-run → exactly one run; done pulses once after 2050 cycles.
- rst_n low at cycle 900, released at 905, then start → all outputs 0 during reset, no done pulse; the new run completes with pass=1.
- DPM_BIST_INVERT_EN defined, model stores ~data at address 10 only in the second pass → done at cycle 4099, err_count=1, first_err_addr=10.
